// File: rtl/loader_pkg.sv
// rtl/loader_pkg.sv - shared FSM encodings and default framing codes for the instruction loader
package loader_pkg;

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_LOAD  = 3'd1;
    localparam logic [2:0] ST_ESC   = 3'd2;
    localparam logic [2:0] ST_FLUSH = 3'd3;
    localparam logic [2:0] ST_DONE  = 3'd4;

    localparam logic [7:0] DEF_START_CODE = 8'hFE;
    localparam logic [7:0] DEF_END_CODE   = 8'hFF;
    localparam logic [7:0] DEF_ESC_CODE   = 8'hFD;

endpackage

// File: rtl/byte_packer.sv
// rtl/byte_packer.sv - MSB-first byte-to-word assembler with lane counter and zero-padded flush view
module byte_packer #(
    parameter int INSTR_W = 32
) (
    input  logic               clk_i,
    input  logic               rst_n_i,
    input  logic               clear_i,
    input  logic               shift_i,
    input  logic [7:0]         byte_i,
    output logic               word_full_o,
    output logic               empty_o,
    output logic [INSTR_W-1:0] word_o,
    output logic [INSTR_W-1:0] pad_word_o
);
    localparam int LANES = INSTR_W / 8;
    localparam int LW    = $clog2(LANES + 1);

    logic [INSTR_W-1:0] asm_q, asm_d;
    logic [LW-1:0]      lane_q, lane_d;

    always_comb begin
        word_o      = {asm_q[INSTR_W-9:0], byte_i};
        word_full_o = shift_i && (lane_q == LW'(LANES - 1));
        empty_o     = (lane_q == '0);
        // Held bytes sit in the low lanes; move them up to the MSB end.
        pad_word_o  = asm_q << (8 * (LANES - int'(lane_q)));
        asm_d       = asm_q;
        lane_d      = lane_q;
        if (clear_i) begin
            asm_d  = '0;
            lane_d = '0;
        end else if (shift_i) begin
            if (word_full_o) begin
                asm_d  = '0;
                lane_d = '0;
            end else begin
                asm_d  = word_o;
                lane_d = lane_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            asm_q  <= '0;
            lane_q <= '0;
        end else begin
            asm_q  <= asm_d;
            lane_q <= lane_d;
        end
    end

endmodule

// File: rtl/instr_stream_loader.sv
// rtl/instr_stream_loader.sv - framed, escaped byte-stream loader writing words into instruction memory
module instr_stream_loader
    import loader_pkg::*;
#(
    parameter int         INSTR_W    = 32,
    parameter int         DEPTH      = 64,
    parameter int         ADDR_W     = $clog2(DEPTH),
    parameter logic [7:0] START_CODE = DEF_START_CODE,
    parameter logic [7:0] END_CODE   = DEF_END_CODE,
    parameter logic [7:0] ESC_CODE   = DEF_ESC_CODE
) (
    input  logic               clk_i,
    input  logic               reset_n,
    input  logic               byte_valid_i,
    input  logic [7:0]         byte_i,
    output logic               byte_ready_o,
    output logic               mem_we_o,
    output logic [ADDR_W-1:0]  mem_addr_o,
    output logic [INSTR_W-1:0] mem_wdata_o,
    output logic               load_busy_o,
    output logic               load_done_o,
    output logic               cpu_start_o,
    output logic [ADDR_W:0]    word_count_o,
    output logic               err_overflow_o,
    output logic               err_partial_o
);
    logic [2:0]         state_q, state_d;
    logic [ADDR_W:0]    cnt_q, cnt_d;
    logic               we_q, we_d, start_q, start_d;
    logic [ADDR_W-1:0]  addr_q, addr_d;
    logic [INSTR_W-1:0] wdata_q, wdata_d;
    logic               ovf_q, ovf_d, part_q, part_d;

    logic               accept, pk_clear, pk_shift, pk_full, pk_empty;
    logic [INSTR_W-1:0] pk_word, pk_pad, commit_word;
    logic               commit;

    assign byte_ready_o = (state_q != ST_FLUSH);
    assign accept       = byte_valid_i && byte_ready_o;

    byte_packer #(.INSTR_W(INSTR_W)) u_packer (
        .clk_i       (clk_i),
        .rst_n_i     (reset_n),
        .clear_i     (pk_clear),
        .shift_i     (pk_shift),
        .byte_i      (byte_i),
        .word_full_o (pk_full),
        .empty_o     (pk_empty),
        .word_o      (pk_word),
        .pad_word_o  (pk_pad)
    );

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        we_d        = 1'b0;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        ovf_d       = ovf_q;
        part_d      = part_q;
        pk_clear    = 1'b0;
        pk_shift    = 1'b0;
        commit      = 1'b0;
        commit_word = pk_word;
        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (accept && byte_i == START_CODE) begin
                    state_d  = ST_LOAD;
                    cnt_d    = '0;
                    ovf_d    = 1'b0;
                    part_d   = 1'b0;
                    pk_clear = 1'b1;
                end
            end
            ST_LOAD: begin
                if (accept) begin
                    if (byte_i == START_CODE) begin
                        cnt_d    = '0;
                        ovf_d    = 1'b0;
                        part_d   = 1'b0;
                        pk_clear = 1'b1;
                    end else if (byte_i == ESC_CODE) begin
                        state_d = ST_ESC;
                    end else if (byte_i == END_CODE) begin
                        if (pk_empty) begin
                            state_d = ST_DONE;
                        end else begin
                            // Padded word is issued at this edge so it is visible during FLUSH.
                            state_d     = ST_FLUSH;
                            commit      = 1'b1;
                            commit_word = pk_pad;
                            part_d      = 1'b1;
                            pk_clear    = 1'b1;
                        end
                    end else begin
                        pk_shift = 1'b1;
                    end
                end
            end
            ST_ESC: begin
                if (accept) begin
                    pk_shift = 1'b1;
                    state_d  = ST_LOAD;
                end
            end
            ST_FLUSH: state_d = ST_DONE;
            default:  state_d = ST_IDLE;
        endcase

        if (pk_full) commit = 1'b1;
        if (commit) begin
            if (cnt_q < (ADDR_W+1)'(DEPTH)) begin
                we_d    = 1'b1;
                addr_d  = cnt_q[ADDR_W-1:0];
                wdata_d = commit_word;
                cnt_d   = cnt_q + 1'b1;
            end else begin
                ovf_d = 1'b1;
            end
        end
        start_d = (state_d == ST_DONE) && (state_q != ST_DONE);
    end

    always_ff @(posedge clk_i or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            start_q <= 1'b0;
            ovf_q   <= 1'b0;
            part_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            start_q <= start_d;
            ovf_q   <= ovf_d;
            part_q  <= part_d;
        end
    end

    assign mem_we_o       = we_q;
    assign mem_addr_o     = addr_q;
    assign mem_wdata_o    = wdata_q;
    assign cpu_start_o    = start_q;
    assign word_count_o   = cnt_q;
    assign err_overflow_o = ovf_q;
    assign err_partial_o  = part_q;
    assign load_done_o    = (state_q == ST_DONE);
    assign load_busy_o    = (state_q == ST_LOAD) || (state_q == ST_ESC) || (state_q == ST_FLUSH);

endmodule

// File: tb/tb_instr_stream_loader.sv
// tb/tb_instr_stream_loader.sv - table-driven frame checks plus reload and async-reset sequences
module tb_instr_stream_loader;
    localparam int INSTR_W = 32;
    localparam int DEPTH   = 4;
    localparam int ADDR_W  = 2;

    logic              clk = 1'b0;
    logic              reset_n;
    logic              byte_valid;
    logic [7:0]        byte_in;
    logic              byte_ready, mem_we, load_busy, load_done, cpu_start, err_ovf, err_part;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic [ADDR_W:0]   word_count;

    instr_stream_loader #(.INSTR_W(INSTR_W), .DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
        .clk_i          (clk),
        .reset_n        (reset_n),
        .byte_valid_i   (byte_valid),
        .byte_i         (byte_in),
        .byte_ready_o   (byte_ready),
        .mem_we_o       (mem_we),
        .mem_addr_o     (mem_addr),
        .mem_wdata_o    (mem_wdata),
        .load_busy_o    (load_busy),
        .load_done_o    (load_done),
        .cpu_start_o    (cpu_start),
        .word_count_o   (word_count),
        .err_overflow_o (err_ovf),
        .err_partial_o  (err_part)
    );

    always #5 clk = ~clk;

    logic [31:0] wq_data[$];
    int          wq_addr[$];
    int          starts = 0;
    int          notready = 0;

    always @(negedge clk) begin
        if (mem_we) begin
            wq_data.push_back(mem_wdata);
            wq_addr.push_back(int'(mem_addr));
        end
        if (cpu_start) starts++;
        if (!byte_ready) notready++;
    end

    int total = 0;
    int bad = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic send(input logic [7:0] b);
        int t;
        @(negedge clk);
        byte_in    = b;
        byte_valid = 1'b1;
        t = 0;
        while (!byte_ready && t < 20) begin
            @(negedge clk);
            t++;
        end
        if (t >= 20) begin
            total++;
            bad++;
            $display("FAIL ready_timeout: got 0 expected 1");
        end
        @(posedge clk);
        #1;
        byte_valid = 1'b0;
    endtask

    typedef struct {
        logic [24*8-1:0] b;
        int              n;
        int              nw;
        logic [4*32-1:0] wd;
        int              cnt;
        logic            ovf;
        logic            part;
    } vec_t;

    vec_t vecs[6];

    initial begin
        int wb, sb, nb, got;
        reset_n    = 1'b0;
        byte_valid = 1'b0;
        byte_in    = 8'h00;

        vecs[0] = '{b: {8'hFE, 32'h12345678, 32'hAABBCCDD, 8'hFF}, n: 10, nw: 2,
                    wd: {32'h12345678, 32'hAABBCCDD}, cnt: 2, ovf: 1'b0, part: 1'b0};
        vecs[1] = '{b: {8'hFE, 8'hFD, 8'hFE, 8'hFD, 8'hFF, 8'h01, 8'hFD, 8'hFD, 8'hFF}, n: 9, nw: 1,
                    wd: {32'hFEFF01FD}, cnt: 1, ovf: 1'b0, part: 1'b0};
        vecs[2] = '{b: {8'hFE, 40'h1122334455, 8'hFF}, n: 7, nw: 2,
                    wd: {32'h11223344, 32'h55000000}, cnt: 2, ovf: 1'b0, part: 1'b1};
        vecs[3] = '{b: {8'hFE, 160'h000102030405060708090A0B0C0D0E0F10111213, 8'hFF}, n: 22, nw: 4,
                    wd: {32'h00010203, 32'h04050607, 32'h08090A0B, 32'h0C0D0E0F}, cnt: 4, ovf: 1'b1, part: 1'b0};
        vecs[4] = '{b: {8'hFE, 8'h01, 8'h02, 8'hFE, 32'h0A0B0C0D, 8'hFF}, n: 9, nw: 1,
                    wd: {32'h0A0B0C0D}, cnt: 1, ovf: 1'b0, part: 1'b0};
        vecs[5] = '{b: {8'h00, 8'h11, 8'hFE, 8'h21, 8'hFD, 8'hFF, 8'hFF}, n: 7, nw: 1,
                    wd: {32'h21FF0000}, cnt: 1, ovf: 1'b0, part: 1'b1};

        repeat (2) @(negedge clk);
        chk("rst_ready", 32'(byte_ready), 32'd1);
        chk("rst_we", 32'(mem_we), 32'd0);
        chk("rst_busy", 32'(load_busy), 32'd0);
        chk("rst_done", 32'(load_done), 32'd0);
        chk("rst_count", 32'(word_count), 32'd0);
        chk("rst_errs", {30'd0, err_ovf, err_part}, 32'd0);
        reset_n = 1'b1;

        for (int v = 0; v < 6; v++) begin
            wb = wq_data.size();
            sb = starts;
            nb = notready;
            for (int i = 0; i < vecs[v].n; i++)
                send(vecs[v].b[(vecs[v].n - 1 - i) * 8 +: 8]);
            repeat (4) @(negedge clk);
            got = wq_data.size() - wb;
            chk($sformatf("v%0d_nwrites", v), 32'(got), 32'(vecs[v].nw));
            for (int j = 0; j < vecs[v].nw && j < got; j++) begin
                chk($sformatf("v%0d_addr%0d", v, j), 32'(wq_addr[wb + j]), 32'(j));
                chk($sformatf("v%0d_data%0d", v, j), wq_data[wb + j],
                    vecs[v].wd[(vecs[v].nw - 1 - j) * 32 +: 32]);
            end
            chk($sformatf("v%0d_count", v), 32'(word_count), 32'(vecs[v].cnt));
            chk($sformatf("v%0d_ovf", v), 32'(err_ovf), 32'(vecs[v].ovf));
            chk($sformatf("v%0d_part", v), 32'(err_part), 32'(vecs[v].part));
            chk($sformatf("v%0d_done", v), 32'(load_done), 32'd1);
            chk($sformatf("v%0d_busy", v), 32'(load_busy), 32'd0);
            chk($sformatf("v%0d_starts", v), 32'(starts - sb), 32'd1);
            chk($sformatf("v%0d_notready", v), 32'(notready - nb), 32'(vecs[v].part));
        end

        send(8'hFE);
        @(negedge clk);
        chk("restart_done", 32'(load_done), 32'd0);
        chk("restart_busy", 32'(load_busy), 32'd1);
        chk("restart_count", 32'(word_count), 32'd0);
        chk("restart_errs", {30'd0, err_ovf, err_part}, 32'd0);

        wb = wq_data.size();
        send(8'h01);
        send(8'h02);
        @(posedge clk);
        #3;
        reset_n = 1'b0;
        #1;
        chk("arst_ready", 32'(byte_ready), 32'd1);
        chk("arst_busy", 32'(load_busy), 32'd0);
        chk("arst_we", 32'(mem_we), 32'd0);
        chk("arst_count", 32'(word_count), 32'd0);
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        chk("arst_nowrite", 32'(wq_data.size() - wb), 32'd0);

        sb = starts;
        send(8'hFE);
        send(8'h01);
        send(8'h02);
        send(8'h03);
        send(8'h04);
        send(8'hFF);
        repeat (4) @(negedge clk);
        got = wq_data.size() - wb;
        chk("post_nwrites", 32'(got), 32'd1);
        if (got > 0) begin
            chk("post_addr", 32'(wq_addr[wb]), 32'd0);
            chk("post_data", wq_data[wb], 32'h01020304);
        end
        chk("post_count", 32'(word_count), 32'd1);
        chk("post_done", 32'(load_done), 32'd1);
        chk("post_starts", 32'(starts - sb), 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
